// File: rtl/midi_poly_parser.sv
// midi_poly_parser
// Polyphonic MIDI byte parser. Consumes bytes from the UART receiver and
// decodes note-on, note-off and control-change messages. It handles running
// status, an optional channel filter, and skips SysEx and real-time bytes.
// Notes are spread across NUM_VOICES voice slots.
//
// Parameters:
//   NUM_VOICES       number of voice slots (1..16)
//   CHANNEL          accepted MIDI channel 0..15, 16 = omni
// Ports:
//   clk              system clock
//   reset            synchronous active-high reset
//   midiByte         received byte, valid while midiReady is high
//   midiReady        one-cycle byte strobe
//   outVoiceNote     7-bit note per voice, voice i at [7i+6:7i]
//   outVoiceVelocity 7-bit velocity per voice, same packing
//   outVoicePlaying  gate per voice
//   outVoiceTrigger  one-cycle pulse when a voice is (re)triggered
//   outEnvAttack     CC 73 value
//   outEnvRelease    CC 72 value
//   outFilterFreq    CC 74 value
//   outWaveSel       CC 0 value bits [6:5]
module midi_poly_parser #(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                midiByte,
    input  logic                      midiReady,
    output logic [7*NUM_VOICES-1:0]   outVoiceNote,
    output logic [7*NUM_VOICES-1:0]   outVoiceVelocity,
    output logic [NUM_VOICES-1:0]     outVoicePlaying,
    output logic [NUM_VOICES-1:0]     outVoiceTrigger,
    output logic [6:0]                outEnvAttack,
    output logic [6:0]                outEnvRelease,
    output logic [6:0]                outFilterFreq,
    output logic [1:0]                outWaveSel
);

    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, DATA1, DATA2, SYSEX} stateT;

    stateT state, nextState;

    // Only the message type nibble of the running status is ever needed;
    // the channel decision is captured separately in accept.
    logic [3:0]            rsStatus;
    logic                  rsValid;
    logic                  accept;
    logic [6:0]            d1;
    logic [PW-1:0]         stealPtr;

    logic [6:0]            voiceNote     [NUM_VOICES];
    logic [6:0]            voiceVelocity [NUM_VOICES];
    logic [NUM_VOICES-1:0] voicePlaying;
    logic [NUM_VOICES-1:0] voiceTrigger;

    logic                  latchStatus, clearRs, storeD1, execMsg;
    logic                  chanMatch, oneByteMsg;
    logic [6:0]            d2;

    logic                  matchFound, freeFound, advanceSteal;
    logic [PW-1:0]         matchIdx, freeIdx, voiceSel;

    assign d2         = midiByte[6:0];
    assign chanMatch  = (CHANNEL == 16) || (midiByte[3:0] == 4'(CHANNEL));
    assign oneByteMsg = (rsStatus == 4'hC) || (rsStatus == 4'hD);

    // Parser state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Byte classification and parser transitions. Real-time bytes fall
    // through with every control low, so nothing about the parse changes.
    always_comb begin
        nextState   = state;
        latchStatus = 1'b0;
        clearRs     = 1'b0;
        storeD1     = 1'b0;
        execMsg     = 1'b0;
        if (midiReady && (midiByte < 8'hF8)) begin
            if (midiByte[7]) begin
                if (midiByte < 8'hF0) begin
                    latchStatus = 1'b1;
                    nextState   = DATA1;
                end else if (midiByte == 8'hF0) begin
                    clearRs   = 1'b1;
                    nextState = SYSEX;
                end else begin
                    clearRs   = 1'b1;
                    nextState = IDLE;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rsValid) begin
                            storeD1   = 1'b1;
                            nextState = oneByteMsg ? IDLE : DATA2;
                        end
                    end
                    DATA1: begin
                        storeD1   = 1'b1;
                        nextState = oneByteMsg ? IDLE : DATA2;
                    end
                    DATA2: begin
                        execMsg   = accept;
                        nextState = IDLE;
                    end
                    SYSEX: nextState = SYSEX;
                    default: nextState = IDLE;
                endcase
            end
        end
    end

    // Voice search: lowest-index voice already sounding d1, else the
    // lowest-index idle voice, else the round-robin steal pointer.
    always_comb begin
        matchFound   = 1'b0;
        matchIdx     = '0;
        freeFound    = 1'b0;
        freeIdx      = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voicePlaying[i] && (voiceNote[i] == d1)) begin
                matchFound = 1'b1;
                matchIdx   = PW'(i);
            end
            if (!voicePlaying[i]) begin
                freeFound = 1'b1;
                freeIdx   = PW'(i);
            end
        end
        advanceSteal = 1'b0;
        if (matchFound)     voiceSel = matchIdx;
        else if (freeFound) voiceSel = freeIdx;
        else begin
            voiceSel     = stealPtr;
            advanceSteal = 1'b1;
        end
    end

    // Running status, stored data and message execution. Triggers are
    // cleared every cycle so a pulse lasts only one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsStatus     <= '0;
            rsValid      <= 1'b0;
            accept       <= 1'b0;
            d1           <= '0;
            stealPtr     <= '0;
            voicePlaying <= '0;
            voiceTrigger <= '0;
            outEnvAttack <= '0;
            outEnvRelease <= '0;
            outFilterFreq <= '0;
            outWaveSel   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voiceNote[i]     <= '0;
                voiceVelocity[i] <= '0;
            end
        end else begin
            voiceTrigger <= '0;
            if (latchStatus) begin
                rsStatus <= midiByte[7:4];
                rsValid  <= 1'b1;
                accept   <= chanMatch;
            end
            if (clearRs) rsValid <= 1'b0;
            if (storeD1) d1 <= midiByte[6:0];
            if (execMsg) begin
                case (rsStatus)
                    4'h9, 4'h8: begin
                        if ((rsStatus == 4'h9) && (d2 != 7'd0)) begin
                            voiceNote[voiceSel]     <= d1;
                            voiceVelocity[voiceSel] <= d2;
                            voicePlaying[voiceSel]  <= 1'b1;
                            voiceTrigger[voiceSel]  <= 1'b1;
                            if (advanceSteal) begin
                                if (stealPtr == PW'(NUM_VOICES - 1)) stealPtr <= '0;
                                else                                 stealPtr <= stealPtr + 1'b1;
                            end
                        end else begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (voicePlaying[i] && (voiceNote[i] == d1)) begin
                                    voicePlaying[i]  <= 1'b0;
                                    voiceVelocity[i] <= '0;
                                end
                            end
                        end
                    end
                    4'hB: begin
                        case (d1)
                            7'd73: outEnvAttack  <= d2;
                            7'd72: outEnvRelease <= d2;
                            7'd74: outFilterFreq <= d2;
                            7'd0:  outWaveSel    <= d2[6:5];
                            7'd120, 7'd123: begin
                                voicePlaying <= '0;
                                for (int i = 0; i < NUM_VOICES; i++) voiceVelocity[i] <= '0;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Flatten the per-voice registers onto the packed output buses.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : gPack
        assign outVoiceNote[7*g +: 7]     = voiceNote[g];
        assign outVoiceVelocity[7*g +: 7] = voiceVelocity[g];
    end
    assign outVoicePlaying = voicePlaying;
    assign outVoiceTrigger = voiceTrigger;

endmodule

// File: tb/tb_midi_poly_parser.sv
// tb_midi_poly_parser
// Self-checking bench for midi_poly_parser. dutA uses the defaults
// (4 voices, omni); dutB uses 2 voices filtered to channel 2. Each table
// entry is a byte sequence and the full expected output state afterwards.
module tb_midi_poly_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byteA, byteB;
    logic        readyA, readyB;

    logic [27:0] noteA, velA;
    logic [3:0]  playA, trigA;
    logic [6:0]  attA, relA, fltA;
    logic [1:0]  waveA;
    logic [13:0] noteB, velB;
    logic [1:0]  playB, trigB;
    logic [6:0]  attB, relB, fltB;
    logic [1:0]  waveB;

    always #5 clk = ~clk;

    midi_poly_parser dutA (
        .clk(clk), .reset(reset), .midiByte(byteA), .midiReady(readyA),
        .outVoiceNote(noteA), .outVoiceVelocity(velA),
        .outVoicePlaying(playA), .outVoiceTrigger(trigA),
        .outEnvAttack(attA), .outEnvRelease(relA),
        .outFilterFreq(fltA), .outWaveSel(waveA)
    );

    midi_poly_parser #(.NUM_VOICES(2), .CHANNEL(2)) dutB (
        .clk(clk), .reset(reset), .midiByte(byteB), .midiReady(readyB),
        .outVoiceNote(noteB), .outVoiceVelocity(velB),
        .outVoicePlaying(playB), .outVoiceTrigger(trigB),
        .outEnvAttack(attB), .outEnvRelease(relB),
        .outFilterFreq(fltB), .outWaveSel(waveB)
    );

    typedef struct {
        logic [27:0] note;
        logic [27:0] vel;
        logic [3:0]  play;
        logic [3:0]  trig;
        logic [6:0]  att;
        logic [6:0]  rel;
        logic [6:0]  flt;
        logic [1:0]  wave;
    } snapT;

    typedef struct {
        int              dutSel;
        int              nBytes;
        logic [4:0][7:0] bytes;
        snapT            exp;
    } vecT;

    vecT vecs[$];
    vecT expQ[$];
    int  errors = 0;
    int  checks = 0;

    function automatic snapT observe(input int sel);
        snapT s;
        if (sel == 0) begin
            s.note = noteA; s.vel = velA; s.play = playA; s.trig = trigA;
            s.att = attA; s.rel = relA; s.flt = fltA; s.wave = waveA;
        end else begin
            s.note = {14'h0, noteB}; s.vel = {14'h0, velB};
            s.play = {2'b0, playB};  s.trig = {2'b0, trigB};
            s.att = attB; s.rel = relB; s.flt = fltB; s.wave = waveB;
        end
        return s;
    endfunction

    function automatic snapT zeroSnap();
        snapT s;
        s.note = '0; s.vel = '0; s.play = '0; s.trig = '0;
        s.att = '0; s.rel = '0; s.flt = '0; s.wave = '0;
        return s;
    endfunction

    task automatic addVec(input int sel, input int n, input logic [4:0][7:0] b,
                          input logic [27:0] note, input logic [27:0] vel,
                          input logic [3:0] play, input logic [3:0] trig,
                          input logic [6:0] att, input logic [6:0] rel,
                          input logic [6:0] flt, input logic [1:0] wave);
        vecT v;
        v.dutSel = sel; v.nBytes = n; v.bytes = b;
        v.exp.note = note; v.exp.vel = vel; v.exp.play = play; v.exp.trig = trig;
        v.exp.att = att; v.exp.rel = rel; v.exp.flt = flt; v.exp.wave = wave;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; holds the strobe for exactly one rising edge
    // and returns at the next falling edge, so consecutive calls are
    // back-to-back strobes.
    task automatic sendByte(input int sel, input logic [7:0] b);
        if (sel == 0) begin byteA = b; readyA = 1'b1; end
        else          begin byteB = b; readyB = 1'b1; end
        @(negedge clk);
        readyA = 1'b0;
        readyB = 1'b0;
    endtask

    task automatic checkField(input string name, input int idx,
                              input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic checkSnap(input int idx, input snapT o, input snapT e);
        checkField("note",     idx, o.note,            e.note);
        checkField("velocity", idx, o.vel,             e.vel);
        checkField("playing",  idx, 28'(o.play),       28'(e.play));
        checkField("trigger",  idx, 28'(o.trig),       28'(e.trig));
        checkField("attack",   idx, 28'(o.att),        28'(e.att));
        checkField("release",  idx, 28'(o.rel),        28'(e.rel));
        checkField("filter",   idx, 28'(o.flt),        28'(e.flt));
        checkField("waveSel",  idx, 28'(o.wave),       28'(e.wave));
    endtask

    task automatic applyStimulus(input int idx);
        vecT v;
        v = vecs[idx];
        for (int k = 0; k < v.nBytes; k++) sendByte(v.dutSel, v.bytes[4-k]);
        expQ.push_back(v);
    endtask

    // Pops the oldest expectation, compares the full state right after the
    // final byte, then confirms the trigger pulse has dropped a cycle later.
    task automatic checkOutput(input int idx);
        vecT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue expected entry", idx);
        end else begin
            e = expQ.pop_front();
            checkSnap(idx, observe(e.dutSel), e.exp);
            @(negedge clk);
            checkField("triggerClear", idx, 28'(observe(e.dutSel).trig), 28'h0);
        end
    endtask

    snapT expR;

    initial begin
        reset = 1'b1; byteA = '0; byteB = '0; readyA = 1'b0; readyB = 1'b0;

        // dutA: 4 voices, omni
        addVec(0, 3, {8'h90,8'h3C,8'h64,8'h00,8'h00}, {21'h0,7'h3C}, {21'h0,7'h64}, 4'b0001, 4'b0001, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 3, {8'h80,8'h3C,8'h00,8'h00,8'h00}, {21'h0,7'h3C}, 28'h0,         4'b0000, 4'b0000, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 3, {8'h90,8'h40,8'h50,8'h00,8'h00}, {21'h0,7'h40}, {21'h0,7'h50}, 4'b0001, 4'b0001, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 3, {8'hF8,8'h43,8'h50,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0010, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 2, {8'h45,8'h00,8'h00,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 4, {8'hF0,8'h49,8'h12,8'hF7,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 2, {8'h3C,8'h64,8'h00,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(0, 3, {8'hB0,8'h49,8'h20,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h20, 7'h00, 7'h00, 2'd0);
        addVec(0, 3, {8'hB0,8'h00,8'h45,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h20, 7'h00, 7'h00, 2'd2);
        addVec(0, 3, {8'hB0,8'h48,8'h11,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h20, 7'h11, 7'h00, 2'd2);
        addVec(0, 3, {8'hB0,8'h4A,8'h33,8'h00,8'h00}, {14'h0,7'h43,7'h40}, {14'h0,7'h50,7'h50}, 4'b0011, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'hB0,8'h7B,8'h00,8'h00,8'h00}, {14'h0,7'h43,7'h40}, 28'h0,               4'b0000, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'h90,8'h10,8'h01,8'h00,8'h00}, {14'h0,7'h43,7'h10}, {21'h0,7'h01},       4'b0001, 4'b0001, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 2, {8'h11,8'h02,8'h00,8'h00,8'h00}, {14'h0,7'h11,7'h10}, {14'h0,7'h02,7'h01}, 4'b0011, 4'b0010, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 2, {8'h12,8'h03,8'h00,8'h00,8'h00}, {7'h0,7'h12,7'h11,7'h10}, {7'h0,7'h03,7'h02,7'h01}, 4'b0111, 4'b0100, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 2, {8'h13,8'h04,8'h00,8'h00,8'h00}, {7'h13,7'h12,7'h11,7'h10}, {7'h04,7'h03,7'h02,7'h01}, 4'b1111, 4'b1000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 2, {8'h14,8'h05,8'h00,8'h00,8'h00}, {7'h13,7'h12,7'h11,7'h14}, {7'h04,7'h03,7'h02,7'h05}, 4'b1111, 4'b0001, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 2, {8'h15,8'h06,8'h00,8'h00,8'h00}, {7'h13,7'h12,7'h15,7'h14}, {7'h04,7'h03,7'h06,7'h05}, 4'b1111, 4'b0010, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 2, {8'h12,8'h7F,8'h00,8'h00,8'h00}, {7'h13,7'h12,7'h15,7'h14}, {7'h04,7'h7F,7'h06,7'h05}, 4'b1111, 4'b0100, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'h80,8'h13,8'h00,8'h00,8'h00}, {7'h13,7'h12,7'h15,7'h14}, {7'h00,7'h7F,7'h06,7'h05}, 4'b0111, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'h90,8'h16,8'h07,8'h00,8'h00}, {7'h16,7'h12,7'h15,7'h14}, {7'h07,7'h7F,7'h06,7'h05}, 4'b1111, 4'b1000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'h90,8'h17,8'h08,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h14}, {7'h07,7'h08,7'h06,7'h05}, 4'b1111, 4'b0100, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 5, {8'h90,8'h3C,8'h80,8'h14,8'h00}, {7'h16,7'h17,7'h15,7'h14}, {7'h07,7'h08,7'h06,7'h00}, 4'b1110, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'hA0,8'h16,8'h55,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h14}, {7'h07,7'h08,7'h06,7'h00}, 4'b1110, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'hC0,8'h05,8'h16,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h14}, {7'h07,7'h08,7'h06,7'h00}, 4'b1110, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 5, {8'hD0,8'h10,8'hE0,8'h01,8'h02}, {7'h16,7'h17,7'h15,7'h14}, {7'h07,7'h08,7'h06,7'h00}, 4'b1110, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'h91,8'h18,8'h09,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h18}, {7'h07,7'h08,7'h06,7'h09}, 4'b1111, 4'b0001, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'h90,8'h17,8'h00,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h18}, {7'h07,7'h00,7'h06,7'h09}, 4'b1011, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'hB0,8'h78,8'h00,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h18}, 28'h0,                     4'b0000, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);
        addVec(0, 3, {8'hB0,8'h10,8'h7F,8'h00,8'h00}, {7'h16,7'h17,7'h15,7'h18}, 28'h0,                     4'b0000, 4'b0000, 7'h20, 7'h11, 7'h33, 2'd2);

        // dutB: 2 voices, channel 2 only
        addVec(1, 3, {8'h91,8'h3C,8'h64,8'h00,8'h00}, 28'h0,                28'h0,                4'b0000, 4'b0000, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 3, {8'h92,8'h3C,8'h64,8'h00,8'h00}, {21'h0,7'h3C},        {21'h0,7'h64},        4'b0001, 4'b0001, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 3, {8'hB1,8'h49,8'h20,8'h00,8'h00}, {21'h0,7'h3C},        {21'h0,7'h64},        4'b0001, 4'b0000, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 3, {8'h92,8'h30,8'h10,8'h00,8'h00}, {14'h0,7'h30,7'h3C},  {14'h0,7'h10,7'h64},  4'b0011, 4'b0010, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 2, {8'h32,8'h10,8'h00,8'h00,8'h00}, {14'h0,7'h30,7'h32},  {14'h0,7'h10,7'h10},  4'b0011, 4'b0001, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 2, {8'h30,8'h7F,8'h00,8'h00,8'h00}, {14'h0,7'h30,7'h32},  {14'h0,7'h7F,7'h10},  4'b0011, 4'b0010, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 2, {8'h33,8'h11,8'h00,8'h00,8'h00}, {14'h0,7'h33,7'h32},  {14'h0,7'h11,7'h10},  4'b0011, 4'b0010, 7'h00, 7'h00, 7'h00, 2'd0);
        addVec(1, 3, {8'hB2,8'h49,8'h20,8'h00,8'h00}, {14'h0,7'h33,7'h32},  {14'h0,7'h11,7'h10},  4'b0011, 4'b0000, 7'h20, 7'h00, 7'h00, 2'd0);
        addVec(1, 3, {8'h81,8'h33,8'h00,8'h00,8'h00}, {14'h0,7'h33,7'h32},  {14'h0,7'h11,7'h10},  4'b0011, 4'b0000, 7'h20, 7'h00, 7'h00, 2'd0);
        addVec(1, 3, {8'h82,8'h33,8'h00,8'h00,8'h00}, {14'h0,7'h33,7'h32},  {14'h0,7'h00,7'h10},  4'b0001, 4'b0000, 7'h20, 7'h00, 7'h00, 2'd0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkSnap(-1, observe(0), zeroSnap());
        checkSnap(-2, observe(1), zeroSnap());

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
            checkOutput(i);
        end

        // Reset in the middle of a note-on, with a strobe in the same cycle.
        sendByte(0, 8'h90);
        sendByte(0, 8'h3C);
        reset = 1'b1; byteA = 8'h64; readyA = 1'b1;
        @(negedge clk);
        reset = 1'b0; readyA = 1'b0;
        checkSnap(100, observe(0), zeroSnap());

        // Running status was cleared, so a lone data byte does nothing.
        sendByte(0, 8'h64);
        checkSnap(101, observe(0), zeroSnap());

        expR = zeroSnap();
        expR.note = {21'h0, 7'h20};
        expR.vel  = {21'h0, 7'h30};
        expR.play = 4'b0001;
        expR.trig = 4'b0001;
        sendByte(0, 8'h90);
        sendByte(0, 8'h20);
        sendByte(0, 8'h30);
        checkSnap(102, observe(0), expR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
